// File: rtl/mem_responder.sv
// mem_responder: valid/ready memory slave with programmable response latency and a host backdoor.
// Optional MEM_RESPONDER_BOUNDS_CHECK_EN adds out-of-range detection with a sticky err output.
module mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned AW      = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [64:0]   req_data,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [64:0]   resp_data,
    input  logic          host_we,
    input  logic          host_re,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic [31:0]   host_rdata,
    output logic          busy
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    ,
    output logic          err
`endif
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   mem [DEPTH];

    logic          req_store;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [AW-1:0] req_idx;
    logic          accept;
    logic          core_we;
    logic [31:0]   resp_word;

    assign req_store = req_data[64];
    assign req_addr  = req_data[63:32];
    assign req_wdata = req_data[31:0];
    assign req_idx   = req_addr[AW+1:2];

    assign req_ready = (state == IDLE) && !host_we && !host_re;
    assign accept    = req_valid && req_ready;

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);

    logic oob;
    assign oob       = (req_addr[31:2] >= DEPTH_W);
    assign core_we   = accept && req_store && !oob;
    assign resp_word = req_store ? req_wdata : (oob ? 32'hDEADBEEF : mem[req_idx]);

    // Sticky out-of-range flag, set on the accept edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (accept && oob) begin
            err <= 1'b1;
        end
    end
`else
    assign core_we   = accept && req_store;
    assign resp_word = req_store ? req_wdata : mem[req_idx];
`endif

    // Word array; host and core writes never coincide since host access blocks accepts.
    always_ff @(posedge clock) begin
        if (host_we) begin
            mem[host_addr] <= host_wdata;
        end else if (core_we) begin
            mem[req_idx] <= req_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            host_rdata <= 32'h0;
        end else if (host_re && !host_we) begin
            host_rdata <= mem[host_addr];
        end
    end

    // Request/response FSM; the counter counts down the remaining WAIT cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        resp_data <= {req_store, req_addr, resp_word};
                        cnt       <= CW'(LATENCY - 1);
                        busy      <= 1'b1;
                        if (LATENCY > 1) begin
                            state <= WAIT;
                        end else begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed plan items plus randomized traffic against a
// cycle-count based reference model. Bounds checks compile in with MEM_RESPONDER_BOUNDS_CHECK_EN.
module tb_mem_responder;

    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned AW      = 10;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [64:0]   req_data = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [64:0]   resp_data;
    logic          host_we = 1'b0;
    logic          host_re = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [31:0]   host_wdata = '0;
    logic [31:0]   host_rdata;
    logic          busy;
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
    logic          err;
`endif

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY), .AW(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .host_we    (host_we),
        .host_re    (host_re),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_rdata (host_rdata),
        .busy       (busy)
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        ,
        .err        (err)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a transaction is in flight from its accept cycle until the handshake,
    // and its response is visible from LATENCY cycles after the accept cycle.
    logic [31:0] ref_mem [DEPTH];
    bit          m_inf = 1'b0;
    bit          m_rv  = 1'b0;
    bit          m_err = 1'b0;
    int          cyc   = 0;
    int          acc   = 0;
    logic [64:0] m_rd  = '0;
    logic [31:0] m_hrd = '0;

    always @(negedge clock) begin
        bit          rr;
        bit          oob;
        logic [31:0] a;
        logic [31:0] d;
        int unsigned idx;
        if (!reset) begin
            m_inf = 1'b0;
            m_rv  = 1'b0;
            m_rd  = '0;
            m_hrd = '0;
            m_err = 1'b0;
        end
        rr = !m_inf && !host_we && !host_re;
        chk("req_ready", 65'(req_ready), 65'(rr));
        chk("resp_valid", 65'(resp_valid), 65'(m_rv));
        chk("busy", 65'(busy), 65'(m_inf));
        chk("resp_data", resp_data, m_rd);
        chk("host_rdata", 65'(host_rdata), 65'(m_hrd));
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        chk("err", 65'(err), 65'(m_err));
`endif
        if (reset) begin
            if (m_inf && m_rv && resp_ready) begin
                m_inf = 1'b0;
            end else if (req_valid && rr) begin
                a   = req_data[63:32];
                oob = BOUNDS && ((a >> 2) >= DEPTH);
                idx = (a >> 2) % DEPTH;
                if (req_data[64]) begin
                    d = req_data[31:0];
                    if (!oob) ref_mem[idx] = d;
                end else begin
                    d = oob ? 32'hDEADBEEF : ref_mem[idx];
                end
                m_rd  = {req_data[64], a, d};
                m_inf = 1'b1;
                acc   = cyc;
                if (oob) m_err = 1'b1;
            end
            if (host_we) ref_mem[host_addr] = host_wdata;
            else if (host_re) m_hrd = ref_mem[host_addr];
            m_rv = m_inf && ((cyc + 1 - acc) >= int'(LATENCY));
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic host_write(input int unsigned a, input logic [31:0] d);
        host_we    = 1'b1;
        host_addr  = AW'(a);
        host_wdata = d;
        tick();
        host_we = 1'b0;
    endtask

    task automatic host_read(input int unsigned a, output logic [31:0] d);
        host_re   = 1'b1;
        host_addr = AW'(a);
        tick();
        host_re = 1'b0;
        d = host_rdata;
    endtask

    task automatic send(input logic st, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_data  = {st, a, d};
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            ok = req_ready;
            tick();
            if (ok) break;
        end
        req_valid = 1'b0;
        chk("accept_timeout", 65'(ok), 65'(1));
    endtask

    task automatic wait_resp(output int k);
        k = 0;
        while (!resp_valid && k < 50) begin
            tick();
            k++;
        end
        chk("resp_timeout", 65'(resp_valid), 65'(1));
    endtask

    initial begin
        int          k;
        logic [31:0] d;
        logic [19:0] upper;
        logic [31:0] a;

        tick(); tick(); tick();
        chk("rst_req_ready", 65'(req_ready), 65'(1));
        chk("rst_resp_valid", 65'(resp_valid), 65'(0));
        chk("rst_busy", 65'(busy), 65'(0));
        chk("rst_resp_data", resp_data, 65'(0));
        reset = 1'b1;
        tick();

        for (int i = 0; i < 16; i++) host_write(i, $urandom);

        // Host load then core load, held under backpressure.
        host_write(5, 32'h12345678);
        resp_ready = 1'b0;
        send(1'b0, 32'h14, 32'h0);
        wait_resp(k);
        chk("load_latency", 65'(k + 1), 65'(3));
        chk("load_data", resp_data, {1'b0, 32'h14, 32'h12345678});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 65'(resp_valid), 65'(1));
            chk("bp_data", resp_data, {1'b0, 32'h14, 32'h12345678});
            chk("bp_req_ready", 65'(req_ready), 65'(0));
        end
        resp_ready = 1'b1;
        tick();
        chk("post_hs_req_ready", 65'(req_ready), 65'(1));
        chk("post_hs_valid", 65'(resp_valid), 65'(0));

        // Core store then host read.
        send(1'b1, 32'h8, 32'hCAFEF00D);
        wait_resp(k);
        chk("store_data", 65'(resp_data[31:0]), 65'(32'hCAFEF00D));
        tick();
        host_read(2, d);
        chk("store_host_rd", 65'(d), 65'(32'hCAFEF00D));

        // Host collision in IDLE blocks the accept; host write in WAIT leaves the response alone.
        req_valid  = 1'b1;
        req_data   = {1'b0, 32'h14, 32'h0};
        host_we    = 1'b1;
        host_addr  = AW'(5);
        host_wdata = 32'h0BADF00D;
        @(negedge clock);
        chk("coll_req_ready", 65'(req_ready), 65'(0));
        tick();
        chk("coll_busy", 65'(busy), 65'(0));
        host_we = 1'b0;
        send(1'b0, 32'h14, 32'h0);
        host_write(5, 32'h11111111);
        wait_resp(k);
        chk("coll_resp_data", resp_data, {1'b0, 32'h14, 32'h0BADF00D});
        tick();
        host_read(5, d);
        chk("coll_host_rd", 65'(d), 65'(32'h11111111));

`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        host_write(0, 32'h600D0000);
        send(1'b0, 32'h1000, 32'h0);
        wait_resp(k);
        chk("oob_load_data", 65'(resp_data[31:0]), 65'(32'hDEADBEEF));
        tick();
        chk("oob_err", 65'(err), 65'(1));
        send(1'b1, 32'h1000, 32'h7);
        wait_resp(k);
        tick();
        host_read(0, d);
        chk("oob_word0", 65'(d), 65'(32'h600D0000));
        chk("oob_err_sticky", 65'(err), 65'(1));
`endif

        // Reset while in WAIT drops the transaction.
        send(1'b0, 32'h14, 32'h0);
        chk("midwait_busy", 65'(busy), 65'(1));
        reset = 1'b0;
        tick();
        chk("midrst_valid", 65'(resp_valid), 65'(0));
        chk("midrst_busy", 65'(busy), 65'(0));
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
        chk("midrst_err", 65'(err), 65'(0));
`endif
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("postrst_valid", 65'(resp_valid), 65'(0));
        end
        chk("postrst_req_ready", 65'(req_ready), 65'(1));

        // Randomized traffic checked by the model.
        for (int i = 0; i < 400; i++) begin
`ifdef MEM_RESPONDER_BOUNDS_CHECK_EN
            upper = ($urandom_range(0, 7) == 0) ? 20'($urandom_range(1, 20'hFFFFF)) : 20'd0;
`else
            upper = 20'($urandom);
`endif
            a          = {upper, 10'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            req_valid  = ($urandom_range(0, 1) == 1);
            req_data   = {1'($urandom_range(0, 1)), a, 32'($urandom)};
            resp_ready = ($urandom_range(0, 9) < 7);
            host_we    = ($urandom_range(0, 19) == 0);
            host_re    = ($urandom_range(0, 19) == 0);
            host_addr  = AW'($urandom_range(0, 15));
            host_wdata = $urandom;
            tick();
        end
        req_valid  = 1'b0;
        host_we    = 1'b0;
        host_re    = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
